// File: rtl/sync_framer.sv
// sync_framer: transmit-side byte framer. Each frame is the 4-byte sync
// word (MSB byte first) followed by PAYLOAD_LEN payload bytes taken from
// the upstream valid/ready source. The output is a single register stage
// with valid/ready backpressure. o_dbg_state exposes the FSM state.
//
// Handshake rules on both sides: a byte moves on a clock edge where
// valid && ready are both high. A valid output byte and its flags stay
// unchanged until it is taken. o_ready never depends on i_valid.
module sync_framer #(
   parameter logic [31:0] SYNC_WORD   = 32'hABCD1234,
   parameter int          PAYLOAD_LEN = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic [7:0] i_data,
   input  logic       i_valid,
   output logic       o_ready,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_ready,
   output logic       o_sof,
   output logic       o_last,
   output logic       o_busy,
   output logic [1:0] o_dbg_state
);

   localparam int                CNT_W    = $clog2(PAYLOAD_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAYLOAD_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SYNC    = 2'd1,
      ST_PAYLOAD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             sof_q, sof_d;
   logic             last_q, last_d;

   logic             out_free;
   logic [7:0]       sync_byte;

   // The output register can take a new byte when empty or being drained.
   assign out_free = !valid_q || i_ready;

   assign o_ready     = (state_q == ST_PAYLOAD) && out_free;
   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_sof       = sof_q;
   assign o_last      = last_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_dbg_state = state_q;

   // Select the sync byte for the current index, MSB byte first.
   always_comb begin
      sync_byte = SYNC_WORD[7:0];
      case (idx_q)
         2'd0:    sync_byte = SYNC_WORD[31:24];
         2'd1:    sync_byte = SYNC_WORD[23:16];
         2'd2:    sync_byte = SYNC_WORD[15:8];
         default: sync_byte = SYNC_WORD[7:0];
      endcase
   end

   // Next-state and output-register load logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      valid_d = valid_q;
      sof_d   = sof_q;
      last_d  = last_q;

      // A consumed byte empties the register unless something reloads it below.
      if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            // i_valid only signals pending payload; nothing is consumed here.
            if (i_enable && i_valid && out_free) begin
               data_d  = SYNC_WORD[31:24];
               valid_d = 1'b1;
               sof_d   = 1'b1;
               last_d  = 1'b0;
               idx_d   = 2'd1;
               state_d = ST_SYNC;
            end
         end

         ST_SYNC: begin
            if (out_free) begin
               data_d  = sync_byte;
               valid_d = 1'b1;
               sof_d   = 1'b0;
               last_d  = 1'b0;
               if (idx_q == 2'd3) begin
                  idx_d   = 2'd0;
                  cnt_d   = '0;
                  state_d = ST_PAYLOAD;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end

         ST_PAYLOAD: begin
            // Accepting a byte and loading it into the output happen together.
            if (i_valid && out_free) begin
               data_d  = i_data;
               valid_d = 1'b1;
               sof_d   = 1'b0;
               if (cnt_q == LAST_CNT) begin
                  last_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  last_d = 1'b0;
                  cnt_d  = cnt_q + CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state, counters and output register; reset abandons any partial frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= 2'd0;
         cnt_q   <= '0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         sof_q   <= sof_d;
         last_q  <= last_d;
      end
   end

endmodule

// File: tb/tb_sync_framer.sv
// tb_sync_framer: directed bench for sync_framer with PAYLOAD_LEN=4.
// Inputs change 1 time unit after the rising edge; outputs are read at the
// same point. Upstream acceptance is sampled at the falling edge.
module tb_sync_framer;

   localparam int LEN = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       i_enable;
   logic [7:0] i_data;
   logic       i_valid;
   logic       o_ready;
   logic [7:0] o_data;
   logic       o_valid;
   logic       i_ready;
   logic       o_sof;
   logic       o_last;
   logic       o_busy;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;

   logic [7:0] up_q[$];
   logic       up_en;
   logic [7:0] exp_q[$];

   sync_framer #(
      .SYNC_WORD   (32'hABCD1234),
      .PAYLOAD_LEN (LEN)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_enable    (i_enable),
      .i_data      (i_data),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_sof       (o_sof),
      .o_last      (o_last),
      .o_busy      (o_busy),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic drive_up();
      i_valid = up_en && (up_q.size() != 0);
      i_data  = (up_q.size() != 0) ? up_q[0] : 8'h00;
   endtask

   task automatic tick();
      logic       acc;
      logic [7:0] junk;
      @(negedge clk);
      acc = i_valid && o_ready;
      @(posedge clk);
      #1;
      if (acc && up_q.size() != 0) junk = up_q.pop_front();
      drive_up();
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      i_enable = 1'b0;
      i_valid  = 1'b0;
      i_data   = 8'h00;
      i_ready  = 1'b0;
      up_en    = 1'b0;
      up_q.delete();
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n    = 1'b0;
      i_enable = 1'b1;
      i_valid  = 1'b1;
      i_data   = 8'h55;
      i_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_data !== 8'h00 || o_sof !== 1'b0 || o_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_out: got valid=%b data=%h sof=%b last=%b, expected all 0",
                  o_valid, o_data, o_sof, o_last);
      end
      checks++;
      if (o_ready !== 1'b0 || o_busy !== 1'b0 || dbg_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got ready=%b busy=%b state=%0d, expected 0 0 0",
                  o_ready, o_busy, dbg_state);
      end
   endtask

   task automatic test_basic();
      logic [7:0] e;
      logic [1:0] es;
      do_reset();
      exp_q = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04};
      up_q  = '{8'h01, 8'h02, 8'h03, 8'h04};
      up_en = 1'b1; i_enable = 1'b1; i_ready = 1'b1;
      drive_up();
      for (int k = 1; k <= 8; k++) begin
         tick();
         e  = exp_q.pop_front();
         es = (k <= 3) ? 2'd1 : ((k <= 7) ? 2'd2 : 2'd0);
         checks++;
         if (o_valid !== 1'b1 || o_data !== e) begin
            errors++;
            $display("FAIL basic_data[%0d]: got valid=%b data=%h, expected valid=1 data=%h",
                     k, o_valid, o_data, e);
         end
         checks++;
         if (o_sof !== (k == 1) || o_last !== (k == 8)) begin
            errors++;
            $display("FAIL basic_flags[%0d]: got sof=%b last=%b, expected sof=%b last=%b",
                     k, o_sof, o_last, (k == 1), (k == 8));
         end
         checks++;
         if (o_busy !== (k != 8) || o_ready !== (k >= 4 && k <= 7)) begin
            errors++;
            $display("FAIL basic_ctrl[%0d]: got busy=%b ready=%b, expected busy=%b ready=%b",
                     k, o_busy, o_ready, (k != 8), (k >= 4 && k <= 7));
         end
         checks++;
         if (dbg_state !== es) begin
            errors++;
            $display("FAIL basic_state[%0d]: got %0d, expected %0d", k, dbg_state, es);
         end
      end
      tick();
      checks++;
      if (o_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_drain: got valid=%b, expected 0", o_valid);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] e;
      logic [7:0] held;
      do_reset();
      exp_q = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04};
      up_q  = '{8'h01, 8'h02, 8'h03, 8'h04};
      up_en = 1'b1; i_enable = 1'b1; i_ready = 1'b1;
      drive_up();
      for (int k = 1; k <= 8; k++) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (o_valid !== 1'b1 || o_data !== e || o_last !== (k == 8)) begin
            errors++;
            $display("FAIL bp_data[%0d]: got valid=%b data=%h last=%b, expected valid=1 data=%h last=%b",
                     k, o_valid, o_data, o_last, e, (k == 8));
         end
         // Stall downstream while CD (sync) and 02 (payload) are presented.
         if (k == 2 || k == 6) begin
            held    = e;
            i_ready = 1'b0;
            #1;
            for (int s = 0; s < ((k == 2) ? 3 : 2); s++) begin
               checks++;
               if (o_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL bp_ready[%0d.%0d]: got %b, expected 0", k, s, o_ready);
               end
               tick();
               checks++;
               if (o_valid !== 1'b1 || o_data !== held || o_sof !== 1'b0 || o_last !== 1'b0) begin
                  errors++;
                  $display("FAIL bp_hold[%0d.%0d]: got valid=%b data=%h sof=%b last=%b, expected 1 %h 0 0",
                           k, s, o_valid, o_data, o_sof, o_last, held);
               end
            end
            i_ready = 1'b1;
         end
      end
      tick();
      checks++;
      if (o_valid !== 1'b0 || up_q.size() != 0) begin
         errors++;
         $display("FAIL bp_drain: got valid=%b pending=%0d, expected 0 0", o_valid, up_q.size());
      end
   endtask

   task automatic test_gap();
      logic [7:0] e;
      do_reset();
      exp_q = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'h01, 8'h02};
      up_q  = '{8'h01, 8'h02};
      up_en = 1'b1; i_enable = 1'b1; i_ready = 1'b1;
      drive_up();
      for (int k = 1; k <= 6; k++) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (o_valid !== 1'b1 || o_data !== e) begin
            errors++;
            $display("FAIL gap_data[%0d]: got valid=%b data=%h, expected valid=1 data=%h",
                     k, o_valid, o_data, e);
         end
      end
      for (int g = 0; g < 2; g++) begin
         tick();
         checks++;
         if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL gap_idle[%0d]: got valid=%b ready=%b busy=%b, expected 0 1 1",
                     g, o_valid, o_ready, o_busy);
         end
      end
      up_q.push_back(8'h03);
      up_q.push_back(8'h04);
      drive_up();
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h03 || o_last !== 1'b0) begin
         errors++;
         $display("FAIL gap_resume: got valid=%b data=%h last=%b, expected 1 03 0",
                  o_valid, o_data, o_last);
      end
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h04 || o_last !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL gap_last: got valid=%b data=%h last=%b busy=%b, expected 1 04 1 0",
                  o_valid, o_data, o_last, o_busy);
      end
   endtask

   task automatic test_enable();
      logic [7:0] e;
      do_reset();
      exp_q = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04};
      up_q  = '{8'h01, 8'h02, 8'h03, 8'h04};
      up_en = 1'b1; i_enable = 1'b0; i_ready = 1'b1;
      drive_up();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++;
         if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL en_gated[%0d]: got valid=%b ready=%b busy=%b, expected 0 0 0",
                     k, o_valid, o_ready, o_busy);
         end
      end
      i_enable = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) i_enable = 1'b0;
         e = exp_q.pop_front();
         checks++;
         if (o_valid !== 1'b1 || o_data !== e || o_sof !== (k == 1) || o_last !== (k == 8)) begin
            errors++;
            $display("FAIL en_frame[%0d]: got valid=%b data=%h sof=%b last=%b, expected 1 %h %b %b",
                     k, o_valid, o_data, o_sof, o_last, e, (k == 1), (k == 8));
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      up_q  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      up_en = 1'b1; i_enable = 1'b1; i_ready = 1'b1;
      drive_up();
      repeat (6) tick();
      checks++;
      if (o_data !== 8'h02 || o_ready !== 1'b1 || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre: got data=%h ready=%b busy=%b, expected 02 1 1",
                  o_data, o_ready, o_busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b0 || o_data !== 8'h00) begin
         errors++;
         $display("FAIL arst_now: got valid=%b busy=%b ready=%b data=%h, expected 0 0 0 00",
                  o_valid, o_busy, o_ready, o_data);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_up();
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'hAB || o_sof !== 1'b1) begin
         errors++;
         $display("FAIL arst_restart: got valid=%b data=%h sof=%b, expected 1 AB 1",
                  o_valid, o_data, o_sof);
      end
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'hCD || o_sof !== 1'b0) begin
         errors++;
         $display("FAIL arst_next: got valid=%b data=%h sof=%b, expected 1 CD 0",
                  o_valid, o_data, o_sof);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      do_reset();
      exp_q = '{8'hAB, 8'hCD, 8'h12, 8'h34, 8'h01, 8'h02, 8'h03, 8'h04,
                8'hAB, 8'hCD, 8'h12, 8'h34, 8'h05, 8'h06, 8'h07, 8'h08};
      up_q  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      up_en = 1'b1; i_enable = 1'b1; i_ready = 1'b1;
      drive_up();
      for (int k = 1; k <= 16; k++) begin
         tick();
         e = exp_q.pop_front();
         checks++;
         if (o_valid !== 1'b1 || o_data !== e) begin
            errors++;
            $display("FAIL b2b_data[%0d]: got valid=%b data=%h, expected valid=1 data=%h",
                     k, o_valid, o_data, e);
         end
         checks++;
         if (o_sof !== (k == 1 || k == 9) || o_last !== (k == 8 || k == 16)) begin
            errors++;
            $display("FAIL b2b_flags[%0d]: got sof=%b last=%b, expected sof=%b last=%b",
                     k, o_sof, o_last, (k == 1 || k == 9), (k == 8 || k == 16));
         end
         // The single idle cycle is the one where the last payload byte sits.
         checks++;
         if (o_busy !== !(k == 8 || k == 16)) begin
            errors++;
            $display("FAIL b2b_busy[%0d]: got %b, expected %b", k, o_busy, !(k == 8 || k == 16));
         end
      end
      tick();
      checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_end: got valid=%b busy=%b, expected 0 0", o_valid, o_busy);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gap();
      test_enable();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
